trace_sequencer: RTL and testbench

- Per-frame controller that walks the captured sample buffer and drives the line-drawing engine one segment at a time, so the scope trace renders as connected line segments.
- Sits between the sample RAM (synchronous read) and the line drawer (start/done handshake).
- Converts samples to screen coordinates, issues segment (x_i,y_i)->(x_i+1,y_i+1), and waits for done before the next segment.

---
 rtl/trace_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_trace_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_sequencer.sv
// Per-frame trace sequencer: reads the captured sample buffer one sample per
// segment, maps samples to screen y, and hands each (x_i,y_i)->(x_i+1,y_i+1)
// segment to the line drawer, waiting for its done pulse before moving on.
module trace_sequencer #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 10,
  parameter int NUM_SEG  = 639,
  parameter int X_BASE   = 0,
  parameter int X_STEP   = 1,
  parameter int Y_BASE   = 112,
  parameter int Y_SHIFT  = 0,
  parameter int V_MAX    = 479
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                frame_start,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [SAMPLE_W-1:0] mem_data,
  output logic                ld_start,
  output logic [9:0]          ld_x0,
  output logic [9:0]          ld_y0,
  output logic [9:0]          ld_x1,
  output logic [9:0]          ld_y1,
  input  logic                ld_done,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_overrun,
  output logic [ADDR_W-1:0]   seg_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_CAP0,
    S_RD,
    S_CAP,
    S_ISSUE,
    S_WAITD,
    S_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   seg_idx_q, seg_idx_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [9:0]          y_prev_q, y_prev_d;
  logic [9:0]          y_cur_q, y_cur_d;
  logic [9:0]          ld_x0_q, ld_x0_d;
  logic [9:0]          ld_y0_q, ld_y0_d;
  logic [9:0]          ld_x1_q, ld_x1_d;
  logic [9:0]          ld_y1_q, ld_y1_d;
  logic                mem_rd_q, mem_rd_d;
  logic                ld_start_q, ld_start_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_overrun_q, frame_overrun_d;
  logic [9:0]          y_map;

  // Inverted sample (larger sample = higher on screen), shifted, offset and
  // clamped to the visible area. (2^W-1)-s is simply the bitwise inverse.
  function automatic logic [9:0] map_sample(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] t;
    logic [10:0]         y;
    t = (~s) >> Y_SHIFT;
    y = 11'(Y_BASE) + 11'(t);
    if (y > 11'(V_MAX)) y = 11'(V_MAX);
    return y[9:0];
  endfunction

  // Next-state, datapath updates and registered Moore output decodes.
  // NOTE: every variable gets a default first so no path can leave one
  // unassigned and infer a latch; combinational blocks use blocking '='.
  always_comb begin
    state_d    = state_q;
    seg_idx_d  = seg_idx_q;
    mem_addr_d = mem_addr_q;
    y_prev_d   = y_prev_q;
    y_cur_d    = y_cur_q;
    ld_x0_d    = ld_x0_q;
    ld_y0_d    = ld_y0_q;
    ld_x1_d    = ld_x1_q;
    ld_y1_d    = ld_y1_q;
    y_map      = map_sample(mem_data);

    case (state_q)
      S_IDLE: begin
        if (frame_start && enable) begin
          state_d    = S_RD0;
          seg_idx_d  = '0;
          mem_addr_d = '0;
        end
      end
      S_RD0:  state_d = S_CAP0;
      S_CAP0: begin
        y_prev_d   = y_map;
        mem_addr_d = seg_idx_q + ADDR_W'(1);
        state_d    = S_RD;
      end
      S_RD:   state_d = S_CAP;
      S_CAP: begin
        // Coordinates are loaded on entry to ISSUE so they are valid with
        // ld_start and stay untouched until the next CAP.
        y_cur_d = y_map;
        ld_x0_d = 10'(X_BASE + int'(seg_idx_q) * X_STEP);
        ld_x1_d = 10'(X_BASE + (int'(seg_idx_q) + 1) * X_STEP);
        ld_y0_d = y_prev_q;
        ld_y1_d = y_map;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAITD;
      S_WAITD: begin
        if (ld_done) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (seg_idx_q == ADDR_W'(NUM_SEG - 1)) begin
            state_d = S_FIN;
          end else begin
            // Shared endpoint: the current sample becomes the next start.
            y_prev_d   = y_cur_q;
            seg_idx_d  = seg_idx_q + ADDR_W'(1);
            mem_addr_d = seg_idx_q + ADDR_W'(2);
            state_d    = S_RD;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_rd_d        = (state_d == S_RD0) || (state_d == S_RD);
    ld_start_d      = (state_d == S_ISSUE);
    frame_done_d    = (state_d == S_FIN);
    busy_d          = (state_d != S_IDLE);
    frame_overrun_d = frame_start && (state_q != S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      seg_idx_q       <= '0;
      mem_addr_q      <= '0;
      y_prev_q        <= '0;
      y_cur_q         <= '0;
      ld_x0_q         <= '0;
      ld_y0_q         <= '0;
      ld_x1_q         <= '0;
      ld_y1_q         <= '0;
      mem_rd_q        <= 1'b0;
      ld_start_q      <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      seg_idx_q       <= seg_idx_d;
      mem_addr_q      <= mem_addr_d;
      y_prev_q        <= y_prev_d;
      y_cur_q         <= y_cur_d;
      ld_x0_q         <= ld_x0_d;
      ld_y0_q         <= ld_y0_d;
      ld_x1_q         <= ld_x1_d;
      ld_y1_q         <= ld_y1_d;
      mem_rd_q        <= mem_rd_d;
      ld_start_q      <= ld_start_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  assign mem_rd        = mem_rd_q;
  assign mem_addr      = mem_addr_q;
  assign ld_start      = ld_start_q;
  assign ld_x0         = ld_x0_q;
  assign ld_y0         = ld_y0_q;
  assign ld_x1         = ld_x1_q;
  assign ld_y1         = ld_y1_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign frame_overrun = frame_overrun_q;
  assign seg_idx       = seg_idx_q;

endmodule

// File: tb/tb_trace_sequencer.sv
// Directed bench for trace_sequencer: a 3-segment instance exercises the
// frame walk, handshake, overrun, abort and reset; a 1-segment instance
// exercises saturation and the minimum frame.
`timescale 1ns/1ps
module tb_trace_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, enable;
  // Instance 1: NUM_SEG=3, X_BASE=10, X_STEP=2, Y_BASE=100
  logic       frame_start, mem_rd, ld_start, ld_done, busy, frame_done, frame_overrun;
  logic [9:0] mem_addr, seg_idx, ld_x0, ld_y0, ld_x1, ld_y1;
  logic [7:0] mem_data;
  // Instance 2: NUM_SEG=1, X_BASE=0, X_STEP=1, Y_BASE=400
  logic       frame_start2, mem_rd2, ld_start2, ld_done2, busy2, frame_done2, frame_overrun2;
  logic [9:0] mem_addr2, seg_idx2, ld_x0_2, ld_y0_2, ld_x1_2, ld_y1_2;
  logic [7:0] mem_data2;

  logic [7:0] ram1 [0:3];
  logic [7:0] ram2 [0:1];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, fd_cnt = 0, ov_cnt = 0;
  logic [9:0] rd_log [0:63];
  logic [9:0] ex0, ey0, ex1, ey1;

  always #5 clk = ~clk;

  trace_sequencer #(.NUM_SEG(3), .X_BASE(10), .X_STEP(2), .Y_BASE(100), .Y_SHIFT(0)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .ld_start(ld_start), .ld_x0(ld_x0), .ld_y0(ld_y0), .ld_x1(ld_x1), .ld_y1(ld_y1),
    .ld_done(ld_done), .busy(busy), .frame_done(frame_done),
    .frame_overrun(frame_overrun), .seg_idx(seg_idx)
  );

  trace_sequencer #(.NUM_SEG(1), .X_BASE(0), .X_STEP(1), .Y_BASE(400), .Y_SHIFT(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start2),
    .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .ld_start(ld_start2), .ld_x0(ld_x0_2), .ld_y0(ld_y0_2), .ld_x1(ld_x1_2), .ld_y1(ld_y1_2),
    .ld_done(ld_done2), .busy(busy2), .frame_done(frame_done2),
    .frame_overrun(frame_overrun2), .seg_idx(seg_idx2)
  );

  // Synchronous-read sample RAMs: data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd)  mem_data  <= (mem_addr < 10'd4) ? ram1[mem_addr[1:0]] : 8'h00;
    if (mem_rd2) mem_data2 <= (mem_addr2 < 10'd2) ? ram2[mem_addr2[0]] : 8'h00;
  end

  // Event counters for instance 1 (read strobes with address log, frame_done, overrun).
  always @(negedge clk) begin
    if (mem_rd === 1'b1) begin
      rd_log[rd_cnt[5:0]] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (frame_done === 1'b1)    fd_cnt <= fd_cnt + 1;
    if (frame_overrun === 1'b1) ov_cnt <= ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Waits (bounded) for ld_start on instance 1 and checks latency and endpoints.
  // hold_done keeps a previous ld_done high one extra cycle (lands in RD).
  task automatic wait_issue(input string tag, input int lat, input logic [9:0] x0,
                            input logic [9:0] y0, input logic [9:0] x1,
                            input logic [9:0] y1, input bit hold_done);
    int n;
    n = 0;
    ex0 = x0; ey0 = y0; ex1 = x1; ey1 = y1;
    while (n < 20) begin
      tick();
      n++;
      frame_start = 1'b0;
      if (!(hold_done && n == 1)) ld_done = 1'b0;
      if (ld_start === 1'b1) break;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " x0x1"}, 32'({ld_x0, ld_x1}), 32'({x0, x1}));
    check({tag, " y0y1"}, 32'({ld_y0, ld_y1}), 32'({y0, y1}));
  endtask

  // Four WAITD cycles with stable endpoints, then ld_done.
  // mode 1: frame_start pulse in WAITD; mode 2: enable dropped in WAITD.
  task automatic wait_done(input string tag, input int mode);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check({tag, " wait start"}, 32'(ld_start), 32'd0);
      check({tag, " wait busy"}, 32'(busy), 32'd1);
      check({tag, " hold xy"}, 32'({ld_x0, ld_y0, ld_x1}), 32'({ex0, ey0, ex1}));
      check({tag, " hold y1"}, 32'(ld_y1), 32'(ey1));
      if (mode == 1 && k == 2) frame_start = 1'b1;
      if (mode == 1 && k == 3) frame_start = 1'b0;
      if (mode == 2 && k == 2) enable = 1'b0;
      if (k == 4) ld_done = 1'b1;
    end
  endtask

  // FIN cycle and return to IDLE after the last segment of instance 1.
  task automatic check_fin(input string tag);
    tick();
    ld_done = 1'b0;
    check({tag, " frame_done"}, 32'(frame_done), 32'd1);
    check({tag, " fin busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " done pulse"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    int base, fd0, ov0, n;
    ram1[0] = 8'd255; ram1[1] = 8'd0; ram1[2] = 8'd128; ram1[3] = 8'd255;
    ram2[0] = 8'd0;   ram2[1] = 8'd200;
    reset_n = 1'b0; enable = 1'b0;
    frame_start = 1'b0; ld_done = 1'b0; frame_start2 = 1'b0; ld_done2 = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst mem_rd", 32'(mem_rd), 32'd0);
    check("rst ld_start", 32'(ld_start), 32'd0);
    check("rst flags", 32'({frame_done, frame_overrun}), 32'd0);
    check("rst addr_seg", 32'({mem_addr, seg_idx}), 32'd0);
    check("rst coords", 32'({ld_x0, ld_y0, ld_x1}), 32'd0);
    check("rst y1", 32'(ld_y1), 32'd0);
    check("rst busy2", 32'(busy2), 32'd0);
    reset_n = 1'b1;
    tick();

    // frame_start with enable low: ignored, no overrun
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("dis busy", 32'(busy), 32'd0);
    tick();
    check("dis no rd", 32'(rd_cnt), 32'd0);
    check("dis no ovr", 32'(ov_cnt), 32'd0);

    // Frame A: basic frame, stray ld_done in RD, overrun in WAITD and in FIN
    enable = 1'b1;
    base = rd_cnt; fd0 = fd_cnt; ov0 = ov_cnt;
    frame_start = 1'b1;
    wait_issue("A.s0", 5, 10'd10, 10'd100, 10'd12, 10'd355, 1'b0);
    wait_done("A.s0", 0);
    wait_issue("A.s1", 3, 10'd12, 10'd355, 10'd14, 10'd227, 1'b1);
    wait_done("A.s1", 1);
    wait_issue("A.s2", 3, 10'd14, 10'd227, 10'd16, 10'd100, 1'b0);
    wait_done("A.s2", 0);
    tick();
    ld_done = 1'b0;
    check("A fin frame_done", 32'(frame_done), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("A fin ovr", 32'(frame_overrun), 32'd1);
    check("A idle busy", 32'(busy), 32'd0);
    tick();
    check("A no restart", 32'(busy), 32'd0);
    check("A rd count", 32'(rd_cnt - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check("A rd addr", 32'(rd_log[6'(base + i)]), 32'(i));
    check("A frame_done count", 32'(fd_cnt - fd0), 32'd1);
    check("A overrun count", 32'(ov_cnt - ov0), 32'd2);

    // Frame B: enable dropped during segment 1 of 3
    base = rd_cnt; fd0 = fd_cnt;
    frame_start = 1'b1;
    wait_issue("B.s0", 5, 10'd10, 10'd100, 10'd12, 10'd355, 1'b0);
    wait_done("B.s0", 0);
    wait_issue("B.s1", 3, 10'd12, 10'd355, 10'd14, 10'd227, 1'b0);
    wait_done("B.s1", 2);
    tick();
    ld_done = 1'b0;
    check("B abort busy", 32'(busy), 32'd0);
    repeat (6) tick();
    check("B abort rd count", 32'(rd_cnt - base), 32'd3);
    check("B no frame_done", 32'(fd_cnt - fd0), 32'd0);

    // Frame C: restart from address 0, then async reset during ISSUE
    enable = 1'b1;
    base = rd_cnt;
    frame_start = 1'b1;
    wait_issue("C.s0", 5, 10'd10, 10'd100, 10'd12, 10'd355, 1'b0);
    check("C first addr", 32'(rd_log[6'(base)]), 32'd0);
    reset_n = 1'b0;
    #1;
    check("C rst ld_start", 32'(ld_start), 32'd0);
    check("C rst busy_rd", 32'({busy, mem_rd}), 32'd0);
    check("C rst coords", 32'({ld_x0, ld_y0, ld_x1}), 32'd0);
    check("C rst y1", 32'(ld_y1), 32'd0);
    check("C rst addr_seg", 32'({mem_addr, seg_idx}), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      tick();
      check("C post-rst idle", 32'({busy, ld_start, mem_rd}), 32'd0);
    end
    check("C rd count", 32'(rd_cnt - base), 32'd2);

    // Frame D: full frame after reset
    base = rd_cnt; fd0 = fd_cnt;
    frame_start = 1'b1;
    wait_issue("D.s0", 5, 10'd10, 10'd100, 10'd12, 10'd355, 1'b0);
    wait_done("D.s0", 0);
    wait_issue("D.s1", 3, 10'd12, 10'd355, 10'd14, 10'd227, 1'b0);
    wait_done("D.s1", 0);
    wait_issue("D.s2", 3, 10'd14, 10'd227, 10'd16, 10'd100, 1'b0);
    wait_done("D.s2", 0);
    check_fin("D");
    check("D rd count", 32'(rd_cnt - base), 32'd4);
    check("D frame_done count", 32'(fd_cnt - fd0), 32'd1);

    // Instance 2: NUM_SEG=1, saturation, ld_done during ISSUE ignored
    frame_start2 = 1'b1;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      frame_start2 = 1'b0;
      if (ld_start2 === 1'b1) break;
    end
    check("N1 latency", 32'(n), 32'd5);
    check("N1 x0x1", 32'({ld_x0_2, ld_x1_2}), 32'({10'd0, 10'd1}));
    check("N1 y0 saturated", 32'(ld_y0_2), 32'd479);
    check("N1 y1", 32'(ld_y1_2), 32'd455);
    ld_done2 = 1'b1;
    tick();
    ld_done2 = 1'b0;
    check("N1 issue-done ignored", 32'({busy2, frame_done2}), 32'b10);
    tick();
    check("N1 waiting", 32'({busy2, frame_done2}), 32'b10);
    ld_done2 = 1'b1;
    tick();
    ld_done2 = 1'b0;
    check("N1 frame_done", 32'(frame_done2), 32'd1);
    tick();
    check("N1 idle", 32'({busy2, frame_done2}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
